// File: rtl/knn_pkg.sv
// Shared types and defaults for the KNN accelerator control path.
// Latency: none (types, constants and a width helper only).
// Backpressure: not applicable.
package knn_pkg;

  localparam int KNN_DATA_WIDTH = 32;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_REF,
    POINT_VAL,
    POINT_NAME,
    DONE_WAIT,
    RESULT
  } knnState_t;

  // Bits needed to hold 0..n-1, never less than one bit.
  function automatic int unsigned cntWidth(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/knn_stream_counter.sv
// Wrap counter 0..LAST with a terminal flag, used for the dimension and drain counts.
// Latency: count moves on the edge after advance; terminal is a decode of the count.
// Backpressure: none; holds its value while advance is low, clear has priority.
module knn_stream_counter
  import knn_pkg::*;
#(
  parameter int unsigned LAST = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic advance,
  output logic terminal
);

  localparam int unsigned W = cntWidth(LAST + 1);
  localparam logic [W-1:0] LAST_VAL = W'(LAST);

  logic [W-1:0] count;

  assign terminal = (count == LAST_VAL);

  // Count up on advance, wrap to zero after the terminal value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (advance) begin
      count <= terminal ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/knn_sequencer.sv
// Sequences stream words into knnTop: reference vector, per-point values plus name slot, done, result capture.
// Latency: one cycle from accepted beat to knnEnable; result captured RESULT_DELAY+1 cycles after knnDone rises.
// Backpressure: sReady only in LOAD_REF/POINT_VAL; a low sValid stalls with no enable and frozen counters.
module knn_sequencer
  import knn_pkg::*;
#(
  parameter int DATA_WIDTH   = KNN_DATA_WIDTH,
  parameter int NUM_DIMS     = 5,
  parameter int RESULT_DELAY = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [DATA_WIDTH-1:0] kIn,
  input  logic [DATA_WIDTH-1:0] numPoints,
  input  logic [DATA_WIDTH-1:0] sData,
  input  logic                  sValid,
  output logic                  sReady,
  output logic [DATA_WIDTH-1:0] knnK,
  output logic                  knnEnable,
  output logic                  knnLoadRef,
  output logic [DATA_WIDTH-1:0] knnRefData,
  output logic [DATA_WIDTH-1:0] knnDataValue,
  output logic [DATA_WIDTH-1:0] knnDataName,
  output logic                  knnDone,
  input  logic [DATA_WIDTH-1:0] knnNameOut,
  input  logic [DATA_WIDTH-1:0] knnValueOut,
  output logic [DATA_WIDTH-1:0] resultName,
  output logic [DATA_WIDTH-1:0] resultValue,
  output logic                  resultValid,
  output logic                  busy
);

  knnState_t state, nextState;

  logic                  beat;
  logic                  startAccept;
  logic                  dimLast;
  logic                  drainLast;
  logic                  morePoints;
  logic                  loadRefTail;
  logic [DATA_WIDTH-1:0] kQ;
  logic [DATA_WIDTH-1:0] numPointsQ;
  logic [DATA_WIDTH-1:0] pointCnt;
  logic [DATA_WIDTH:0]   nextPointIdx;

  assign sReady      = (state == LOAD_REF) || (state == POINT_VAL);
  assign beat        = sValid && sReady;
  assign startAccept = start && !abort && (state == IDLE);
  assign busy        = (state != IDLE);
  assign knnDone     = (state == DONE_WAIT) || (state == RESULT);
  assign knnLoadRef  = (state == LOAD_REF) || loadRefTail;
  assign knnK        = kQ;

  // One extra bit so a point count near the top of the range cannot wrap the compare.
  assign nextPointIdx = {1'b0, pointCnt} + {{DATA_WIDTH{1'b0}}, 1'b1};
  assign morePoints   = nextPointIdx < {1'b0, numPointsQ};

  knn_stream_counter #(.LAST(NUM_DIMS - 1)) dimCounter (
    .clk      (clk),
    .reset    (reset),
    .clear    (startAccept || abort),
    .advance  (beat),
    .terminal (dimLast)
  );

  knn_stream_counter #(.LAST(RESULT_DELAY - 1)) drainCounter (
    .clk      (clk),
    .reset    (reset),
    .clear    (startAccept || abort),
    .advance  (state == DONE_WAIT),
    .terminal (drainLast)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= nextState;
  end

  // Next-state decode; abort overrides every transition, including start.
  always_comb begin
    nextState = state;
    if (abort) begin
      nextState = IDLE;
    end else begin
      case (state)
        IDLE:       if (start) nextState = LOAD_REF;
        LOAD_REF:   if (beat && dimLast) nextState = (numPointsQ != '0) ? POINT_VAL : DONE_WAIT;
        POINT_VAL:  if (beat && dimLast) nextState = POINT_NAME;
        POINT_NAME: nextState = morePoints ? POINT_VAL : DONE_WAIT;
        DONE_WAIT:  if (drainLast) nextState = RESULT;
        RESULT:     nextState = IDLE;
        default:    nextState = IDLE;
      endcase
    end
  end

  // Command latches, written only when a start is honoured.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      kQ         <= '0;
      numPointsQ <= '0;
    end else if (startAccept) begin
      kQ         <= kIn;
      numPointsQ <= numPoints;
    end
  end

  // Point index, advanced as each name slot is issued.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pointCnt <= '0;
    end else if (startAccept || abort) begin
      pointCnt <= '0;
    end else if (state == POINT_NAME) begin
      pointCnt <= pointCnt + 1'b1;
    end
  end

  // Datapath strobe and buses; buses hold between enables.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      knnEnable    <= 1'b0;
      loadRefTail  <= 1'b0;
      knnRefData   <= '0;
      knnDataValue <= '0;
      knnDataName  <= '0;
    end else begin
      knnEnable   <= 1'b0;
      loadRefTail <= 1'b0;
      if (!abort) begin
        if (beat) begin
          knnEnable <= 1'b1;
          if (state == LOAD_REF) begin
            knnRefData  <= sData;
            loadRefTail <= dimLast;
          end else begin
            knnDataValue <= sData;
          end
        end else if (state == POINT_NAME) begin
          knnEnable   <= 1'b1;
          knnDataName <= pointCnt;
        end
      end
    end
  end

  // Result capture; the registers keep the last result after the pulse or an abort.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      resultValid <= 1'b0;
      resultName  <= '0;
      resultValue <= '0;
    end else begin
      resultValid <= 1'b0;
      if ((state == RESULT) && !abort) begin
        resultValid <= 1'b1;
        resultName  <= knnNameOut;
        resultValue <= knnValueOut;
      end
    end
  end

endmodule

// File: tb/tb_knn_sequencer.sv
// Scoreboard bench for knn_sequencer: stimulus pushes expected enables/results, a monitor pops and compares.
// Latency: expected cycle offsets are hand-derived from the state sequence.
// Backpressure: sValid gaps and aborts are driven directly from the stimulus process.
module tb_knn_sequencer;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          start, abort;
  logic [DW-1:0] kIn, numPoints, sData;
  logic          sValid, sReady;
  logic [DW-1:0] knnK, knnRefData, knnDataValue, knnDataName;
  logic          knnEnable, knnLoadRef, knnDone;
  logic [DW-1:0] knnNameOut, knnValueOut, resultName, resultValue;
  logic          resultValid, busy;

  always #5 clk = ~clk;

  knn_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .kIn(kIn), .numPoints(numPoints), .sData(sData), .sValid(sValid), .sReady(sReady),
    .knnK(knnK), .knnEnable(knnEnable), .knnLoadRef(knnLoadRef),
    .knnRefData(knnRefData), .knnDataValue(knnDataValue), .knnDataName(knnDataName),
    .knnDone(knnDone), .knnNameOut(knnNameOut), .knnValueOut(knnValueOut),
    .resultName(resultName), .resultValue(resultValue), .resultValid(resultValid), .busy(busy)
  );

  typedef struct { int kind; logic [31:0] val; logic [31:0] k; } enExp_t;   // kind 0 ref, 1 value, 2 name
  typedef struct { logic [31:0] name; logic [31:0] value; } resExp_t;

  enExp_t  enQ[$];
  resExp_t resQ[$];
  enExp_t  e;
  resExp_t r;

  int words[25] = '{1, 2, 2, 2, 3,  5, 10, 7, 9, 6,  1, 1, 1, 1, 1,  2, 2, 2, 2, 2,  5, 5, 5, 5, 5};

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int startCyc = 0;
  int gapCount = 0, doneRiseCyc = 0, resultCyc = 0, resCount = 0;
  bit inRun = 0, prevDone = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents an enable or a result.
  always @(negedge clk) begin
    if (reset) begin
      if (knnEnable) begin
        if (enQ.size() == 0) begin
          tests++; fails++;
          $display("FAIL spurious_enable: knnEnable high with nothing expected (cycle %0d)", cyc);
        end else begin
          e = enQ.pop_front();
          case (e.kind)
            0: begin check("ref_data", 64'(knnRefData), 64'(e.val));    check("ref_loadref", 64'(knnLoadRef), 64'd1); end
            1: begin check("point_value", 64'(knnDataValue), 64'(e.val)); check("value_loadref", 64'(knnLoadRef), 64'd0); end
            default: begin check("point_name", 64'(knnDataName), 64'(e.val)); check("name_loadref", 64'(knnLoadRef), 64'd0); end
          endcase
          check("knn_k", 64'(knnK), 64'(e.k));
        end
      end
      if (knnDone || !busy) inRun = 0;
      if (inRun && !knnEnable) gapCount++;
      if (knnEnable && busy) inRun = 1;
      if (knnDone && !prevDone) doneRiseCyc = cyc;
      prevDone = knnDone;
      if (resultValid) begin
        resCount++;
        resultCyc = cyc;
        if (resQ.size() == 0) begin
          tests++; fails++;
          $display("FAIL spurious_result: resultValid high with nothing expected (cycle %0d)", cyc);
        end else begin
          r = resQ.pop_front();
          check("result_name", 64'(resultName), 64'(r.name));
          check("result_value", 64'(resultValue), 64'(r.value));
        end
      end
    end
  end

  task automatic pushExpect(input int n, input int kVal);
    for (int idx = 0; idx < n; idx++) begin
      if (idx < 5) enQ.push_back('{kind: 0, val: 32'(words[idx]), k: 32'(kVal)});
      else begin
        enQ.push_back('{kind: 1, val: 32'(words[idx]), k: 32'(kVal)});
        if ((idx - 5) % 5 == 4) enQ.push_back('{kind: 2, val: 32'((idx - 5) / 5), k: 32'(kVal)});
      end
    end
  endtask

  task automatic doStart(input int kVal, input int np);
    @(posedge clk); #1;
    kIn = 32'(kVal); numPoints = 32'(np); start = 1'b1; startCyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic streamWords(input int n, input int gapIdx, input int gapLen);
    bit hs;
    int tmo;
    for (int i = 0; i < n; i++) begin
      if (i == gapIdx) begin
        sValid = 1'b0;
        repeat (gapLen) @(posedge clk);
        #1;
      end
      sData = 32'(words[i]); sValid = 1'b1;
      hs = 0; tmo = 0;
      while (!hs && tmo < 50) begin
        @(negedge clk); hs = sReady;
        @(posedge clk); #1;
        tmo++;
      end
      check("stream_handshake", 64'(hs), 64'd1);
    end
  endtask

  task automatic waitResult(input int r0);
    int tmo = 0;
    while (resCount == r0 && tmo < 200) begin
      @(posedge clk); #1; tmo++;
    end
    check("result_seen", 64'(resCount > r0), 64'd1);
  endtask

  task automatic runFull(input int kVal, input int np, input int gapIdx, input bit pokeBusy, input int expDone);
    int g0, r0, nw;
    nw = 5 + 5 * np;
    pushExpect(nw, kVal);
    resQ.push_back('{name: knnNameOut, value: knnValueOut});
    g0 = gapCount; r0 = resCount;
    doStart(kVal, np);
    fork
      streamWords(nw, gapIdx, 3);
      begin
        if (pokeBusy) begin
          repeat (8) @(posedge clk); #1;
          start = 1'b1; kIn = 32'd7; numPoints = 32'd1;
          @(posedge clk); #1;
          start = 1'b0;
        end
      end
    join
    sValid = 1'b0;
    waitResult(r0);
    check("done_latency", 64'(doneRiseCyc - startCyc), 64'(expDone));
    check("result_after_done", 64'(resultCyc - doneRiseCyc), 64'd5);
    check("enable_gap_cycles", 64'(gapCount - g0), (gapIdx >= 0) ? 64'd3 : 64'd0);
    check("enables_consumed", 64'(enQ.size()), 64'd0);
    check("knnK_hold", 64'(knnK), 64'(kVal));
  endtask

  initial begin
    int r0, d0;
    reset = 1'b0; start = 1'b0; abort = 1'b0; kIn = '0; numPoints = '0;
    sData = '0; sValid = 1'b0; knnNameOut = 32'h2; knnValueOut = 32'h1234;
    repeat (2) @(posedge clk); #1;
    check("rst_sReady", 64'(sReady), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_enable", 64'(knnEnable), 64'd0);
    check("rst_loadref", 64'(knnLoadRef), 64'd0);
    check("rst_done", 64'(knnDone), 64'd0);
    check("rst_resultValid", 64'(resultValid), 64'd0);
    check("rst_buses", {knnK, knnRefData} | {knnDataValue, knnDataName} | {resultName, resultValue}, 64'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    // Four points, continuous stream.
    runFull(3, 4, -1, 1'b0, 30);
    // Same stream, 3-cycle sValid gap in point 2, start pulsed while busy.
    runFull(3, 4, 17, 1'b1, 33);

    // Zero points: reference only, then done.
    knnNameOut = 32'h5; knnValueOut = 32'h55;
    runFull(3, 0, -1, 1'b0, 6);
    check("np0_result_cycle", 64'(resultCyc - startCyc), 64'd11);

    // Abort during point 1.
    r0 = resCount; d0 = doneRiseCyc;
    pushExpect(12, 3);
    doStart(3, 4);
    streamWords(12, -1, 3);
    sValid = 1'b0; abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_sReady", 64'(sReady), 64'd0);
    check("abort_enable", 64'(knnEnable), 64'd0);
    check("abort_loadref", 64'(knnLoadRef), 64'd0);
    check("abort_done", 64'(knnDone), 64'd0);
    repeat (10) @(posedge clk); #1;
    check("abort_no_result", 64'(resCount), 64'(r0));
    check("abort_no_done", 64'(doneRiseCyc), 64'(d0));
    check("abort_enables_consumed", 64'(enQ.size()), 64'd0);
    check("abort_result_kept", {resultName, resultValue}, {32'h5, 32'h55});

    // start and abort together in IDLE: stay idle.
    start = 1'b1; abort = 1'b1; kIn = 32'd9;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    check("start_abort_idle", 64'(busy), 64'd0);
    check("start_abort_k", 64'(knnK), 64'd3);

    // Clean rerun from point 0 after the abort.
    runFull(3, 1, -1, 1'b0, 12);

    // Asynchronous reset mid-LOAD_REF.
    pushExpect(1, 4);
    doStart(4, 2);
    streamWords(2, -1, 3);
    #1 reset = 1'b0;
    #1;
    check("arst_sReady", 64'(sReady), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_enable", 64'(knnEnable), 64'd0);
    check("arst_loadref", 64'(knnLoadRef), 64'd0);
    check("arst_buses", {knnK, knnRefData}, 64'd0);
    sValid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check("arst_idle_after", 64'(busy), 64'd0);
    check("arst_enables_consumed", 64'(enQ.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/knn_sequencer.md
# knn_sequencer

Control sequencer for the KNN accelerator datapath (`knnTop`). It accepts a start command with `k` and a point count, then pulls words from a host-side ready/valid stream. It feeds the datapath in its required order: reference vector under `loadRef`, then per point `NUM_DIMS` values followed by a name slot, then `done`. It then captures the result after a fixed drain latency. It sits between the AXI-side FIFO and `knnTop` inside the KNN_accelerator IP.

## Interface
- `DATA_WIDTH`, 32, width of stream words, reference/value/name buses and `k`.
- `NUM_DIMS`, 5, dimensions per vector (≥1).
- `RESULT_DELAY`, 4, cycles from `knnDone` rising to result capture (≥1).

Ports:
- `clk` in 1: single clock, all logic rising-edge.
- `reset` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle command pulse, honoured only in IDLE.
- `abort` in 1: synchronous abort, returns to IDLE.
- `kIn` in DATA_WIDTH: k, latched on accepted `start`.
- `numPoints` in DATA_WIDTH: points to stream, latched on accepted `start`.
- `sData` in DATA_WIDTH: stream word.
- `sValid` in 1: stream word valid.
- `sReady` out 1: sequencer accepts word.
- `knnK` out DATA_WIDTH: k to datapath.
- `knnEnable` out 1: datapath advance strobe; datapath samples inputs only when high.
- `knnLoadRef` out 1: reference-load mode.
- `knnRefData` out DATA_WIDTH: reference dimension value.
- `knnDataValue` out DATA_WIDTH: point dimension value.
- `knnDataName` out DATA_WIDTH: point name (index).
- `knnDone` out 1: end-of-data to datapath.
- `knnNameOut` in DATA_WIDTH: datapath result name.
- `knnValueOut` in DATA_WIDTH: datapath result value.
- `resultName` out DATA_WIDTH: captured name.
- `resultValue` out DATA_WIDTH: captured value.
- `resultValid` out 1: one-cycle capture pulse.
- `busy` out 1: high in every state except IDLE.

## Operation
- States:
  - IDLE → LOAD_REF on `start`.
  - LOAD_REF: accepts `NUM_DIMS` words. Goes to POINT_VAL if `numPoints`≠0, else DONE_WAIT.
  - POINT_VAL: accepts `NUM_DIMS` words, then POINT_NAME.
  - POINT_NAME: one cycle, no word consumed. Goes to POINT_VAL if more points remain, else DONE_WAIT.
  - DONE_WAIT: counts `RESULT_DELAY` cycles, then RESULT.
  - RESULT: one cycle, captures result, → IDLE.
- `sReady` = 1 only in LOAD_REF and POINT_VAL. A beat is accepted when `sValid && sReady`.
- On an accepted beat: `knnEnable`=1 next cycle, with the word on `knnRefData` (LOAD_REF) or `knnDataValue` (POINT_VAL). With no beat, `knnEnable`=0 and buses hold their previous values.
- POINT_NAME drives `knnDataName` = point index (0-based, 32-bit counter) with `knnEnable`=1.
- `knnLoadRef` is high while in LOAD_REF and for the registered output cycle of its last word.
- `knnK` = latched `kIn`, valid from the cycle after `start` until the next `start`.
- `knnDone` is high throughout DONE_WAIT and RESULT, low otherwise.
- RESULT: registers `knnNameOut`/`knnValueOut` into `resultName`/`resultValue`. `resultValid`=1 for that one cycle only; result registers hold afterwards.
- Counters: dimension counter 0..NUM_DIMS-1 wraps at last word. Point counter compares with latched `numPoints`.

## Timing
- Reset: all outputs 0, state IDLE, counters 0, latched k/numPoints 0.
- Registered outputs, 1-cycle latency from accepted beat to `knnEnable`.
- Full throughput: one word per cycle when `sValid` is held. Per point: NUM_DIMS+1 cycles.
- Minimum run with `numPoints`=0: 1 (start) + NUM_DIMS + RESULT_DELAY + 1 cycles to `resultValid`.
- `start` while busy: ignored, latches unchanged.
- `start` and `abort` together in IDLE: abort wins, remain IDLE.
- `abort` in any state: next cycle IDLE; `sReady`, `knnEnable`, `knnLoadRef`, `knnDone` = 0; no `resultValid`. Result registers retain their previous values.
- `sValid` dropping mid-vector: stall with no `knnEnable`; counters frozen.
- Async `reset` mid-run: immediate return to reset values, regardless of clock.

## Structure
- Shared package `knn_pkg`: state enum (IDLE, LOAD_REF, POINT_VAL, POINT_NAME, DONE_WAIT, RESULT) and DATA_WIDTH default, also used by `knnTop` wrappers.
- One natural sub-module: `knn_stream_counter`, a parameterised wrap counter with terminal flag. Instantiated for the dimension counter and the drain counter.

## Test plan
- `start`, k=3, `numPoints`=4. Stream ref 1,2,2,2,3, then values 5,10,7,9,6 / 1×5 / 2×5 / 5×5 with `sValid` always high. Expect `knnLoadRef` for 5 enables, names 0..3 in the name slots, `knnK`=3, `knnDone` after name 3, and `resultValid` RESULT_DELAY+1 cycles later with captured datapath outputs.
- Same stream with `sValid` low for 3 cycles mid-point-2 → `knnEnable` gaps exactly 3 cycles; values and names unchanged.
- `numPoints`=0 → only 5 ref enables, then `knnDone`; `resultValid` at cycle 1+5+4+1.
- `abort` during POINT_VAL of point 1 → next cycle IDLE, `busy`=0, no `knnDone`, no `resultValid`. A new `start` runs cleanly from point 0.
- `start` pulsed while busy with kIn=7 → `knnK` stays 3, sequence unaffected.
- `reset` low asynchronously mid-LOAD_REF → all outputs 0 before the next clock edge; IDLE after release.
